// File: rtl/sd_otf_converter.sv
// On-the-fly conversion of an MSD-first radix-2 signed-digit stream into a
// two's-complement word, handed downstream over a valid/ready handshake.
module sd_otf_converter #(
   parameter int N_DIGITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          digit_in,
   input  logic                In_vld,
   output logic                In_rdy,
   output logic [N_DIGITS:0]   res,
   output logic                res_zero,
   output logic                Out_vld,
   input  logic                Out_rdy
);

   localparam int W     = N_DIGITS + 1;
   localparam int CNT_W = $clog2(N_DIGITS) + 1;

   typedef enum logic {S_COLLECT, S_HOLD} state_t;

   state_t                   state_q, state_d;
   logic signed [W-1:0]      q_q, q_d;
   logic signed [W-1:0]      qm_q, qm_d;
   logic signed [W-1:0]      res_q, res_d;
   logic                     res_zero_q, res_zero_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     in_rdy_q, in_rdy_d;
   logic                     out_vld_q, out_vld_d;
   logic                     dig_acc, res_acc, last_dig;
   logic signed [W-1:0]      q_upd, qm_upd;

   function automatic logic signed [W-1:0] shl_in(input logic signed [W-1:0] x, input logic b);
      shl_in = {x[W-2:0], b};
   endfunction

   assign dig_acc  = In_vld & in_rdy_q;
   assign res_acc  = Out_rdy & out_vld_q;
   assign last_dig = (cnt_q == CNT_W'(N_DIGITS - 1));

   // Digit append: QM = Q - ulp lets a -1 digit borrow without carry propagation
   always_comb begin
      q_upd  = shl_in(q_q, 1'b0);
      qm_upd = shl_in(qm_q, 1'b1);
      case (digit_in)
         2'b10: begin
            q_upd  = shl_in(q_q, 1'b1);
            qm_upd = shl_in(q_q, 1'b0);
         end
         2'b01: begin
            q_upd  = shl_in(qm_q, 1'b1);
            qm_upd = shl_in(qm_q, 1'b0);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      qm_d       = qm_q;
      res_d      = res_q;
      res_zero_d = res_zero_q;
      cnt_d      = cnt_q;
      in_rdy_d   = in_rdy_q;
      out_vld_d  = out_vld_q;
      case (state_q)
         S_COLLECT: begin
            if (dig_acc) begin
               q_d  = q_upd;
               qm_d = qm_upd;
               if (last_dig) begin
                  res_d      = q_upd;
                  res_zero_d = (q_upd == '0);
                  out_vld_d  = 1'b1;
                  in_rdy_d   = 1'b0;
                  cnt_d      = '0;
                  state_d    = S_HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (res_acc) begin
               out_vld_d = 1'b0;
               in_rdy_d  = 1'b1;
               q_d       = '0;
               qm_d      = '1;
               state_d   = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_COLLECT;
         q_q        <= '0;
         qm_q       <= '1;
         res_q      <= '0;
         res_zero_q <= 1'b0;
         cnt_q      <= '0;
         in_rdy_q   <= 1'b1;
         out_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         qm_q       <= qm_d;
         res_q      <= res_d;
         res_zero_q <= res_zero_d;
         cnt_q      <= cnt_d;
         in_rdy_q   <= in_rdy_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign In_rdy   = in_rdy_q;
   assign Out_vld  = out_vld_q;
   assign res      = res_q;
   assign res_zero = res_zero_q;

endmodule

// File: tb/tb_sd_otf_converter.sv
// Directed and random stimulus for sd_otf_converter (N_DIGITS=4) with a
// queue-based scoreboard of expected words built from the digit weights.
module tb_sd_otf_converter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   digit_in;
   logic         In_vld;
   logic         In_rdy;
   logic [N:0]   res;
   logic         res_zero;
   logic         Out_vld;
   logic         Out_rdy;

   int n_total = 0;
   int n_pass  = 0;
   logic [N+1:0] exp_q [$];

   sd_otf_converter #(.N_DIGITS(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .digit_in (digit_in),
      .In_vld   (In_vld),
      .In_rdy   (In_rdy),
      .res      (res),
      .res_zero (res_zero),
      .Out_vld  (Out_vld),
      .Out_rdy  (Out_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
   endtask

   function automatic int dval(input logic [1:0] c);
      dval = int'(c[1]) - int'(c[0]);
   endfunction

   task automatic send_digit(input logic [1:0] code, input int gap);
      int t;
      repeat (gap) begin
         @(negedge clk);
         In_vld = 1'b0;
      end
      t = 0;
      @(negedge clk);
      while (!In_rdy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("in_rdy_timeout", 32'd0, 32'd1);
      chk("mutex_in", 32'(Out_vld), 32'd0);
      digit_in = code;
      In_vld   = 1'b1;
      @(posedge clk);
      #1 In_vld = 1'b0;
   endtask

   task automatic send_word(input logic [2*N-1:0] codes, input int maxgap);
      int v;
      logic [N:0] r;
      v = 0;
      for (int i = 0; i < N; i++)
         v += dval(codes[2*N-1-2*i -: 2]) * (1 << (N - 1 - i));
      r = v[N:0];
      exp_q.push_back({(v == 0), r});
      for (int i = 0; i < N; i++)
         send_digit(codes[2*N-1-2*i -: 2], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic get_result(input int hold, input bit offer);
      int t;
      logic [N+1:0] e;
      t = 0;
      @(negedge clk);
      while (!Out_vld && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("latency", 32'(t), 32'd0);
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd0, 32'd1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      chk("res", 32'(res), 32'(e[N:0]));
      chk("res_zero", 32'(res_zero), 32'(e[N+1]));
      chk("in_rdy_hold", 32'(In_rdy), 32'd0);
      for (int i = 0; i < hold; i++) begin
         if (offer && i == 0) begin
            digit_in = 2'b10;
            In_vld   = 1'b1;
         end
         @(negedge clk);
         chk("hold_vld", 32'(Out_vld), 32'd1);
         chk("hold_res", 32'(res), 32'(e[N:0]));
         chk("hold_in_rdy", 32'(In_rdy), 32'd0);
      end
      In_vld  = 1'b0;
      Out_rdy = 1'b1;
      @(posedge clk);
      #1 Out_rdy = 1'b0;
      @(negedge clk);
      chk("out_vld_drop", 32'(Out_vld), 32'd0);
      chk("in_rdy_back", 32'(In_rdy), 32'd1);
   endtask

   initial begin
      logic [31:0] rnd;
      logic [2*N-1:0] codes;
      rst = 1'b1; digit_in = 2'b00; In_vld = 1'b0; Out_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_rdy", 32'(In_rdy), 32'd1);
      chk("rst_out_vld", 32'(Out_vld), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_res_zero", 32'(res_zero), 32'd0);

      // Out_rdy high while idle must not matter
      Out_rdy = 1'b1;
      @(negedge clk);
      chk("idle_out_rdy", 32'(Out_vld), 32'd0);
      Out_rdy = 1'b0;

      send_word(8'b10_00_01_10, 0);   // +1 0 -1 +1 -> 7/16
      get_result(0, 1'b0);
      send_word(8'b01_01_01_01, 0);   // -15/16
      get_result(0, 1'b0);
      send_word(8'b01_10_10_10, 0);   // -1/16
      get_result(0, 1'b0);
      send_word(8'b00_11_00_11, 0);   // zero, with 11 encodings
      get_result(0, 1'b0);
      send_word(8'b10_10_10_10, 0);   // 15/16
      get_result(0, 1'b0);

      // Gappy input, long hold with a digit offered during HOLD
      send_word(8'b10_01_00_01, 2);
      get_result(5, 1'b1);
      send_word(8'b10_00_00_00, 0);
      get_result(0, 1'b0);

      // Reset mid-word discards the partial digits
      send_digit(2'b10, 0);
      send_digit(2'b01, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_vld", 32'(Out_vld), 32'd0);
      chk("midrst_in_rdy", 32'(In_rdy), 32'd1);
      send_word(8'b10_00_00_00, 0);
      get_result(0, 1'b0);

      for (int w = 0; w < 1000; w++) begin
         for (int i = 0; i < N; i++) begin
            rnd = $urandom_range(0, 3);
            codes[2*i +: 2] = rnd[1:0];
         end
         send_word(codes, 1);
         get_result(int'($urandom_range(0, 2)), 1'b0);
      end

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
